// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// seg_scan_driver
// Time-multiplexed 7-segment scan driver for DIGITS common-enable digits.
// It has per-digit decimal point, blank and blink controls, and PWM brightness.
// The inputs are double buffered: a load strobe writes the shadow registers.
// The shadow registers move to the active set only at a frame boundary, so a
// displayed frame never tears.
// Digit 0 is the leftmost digit. It shows the most significant nibble of
// digit_data.
// Build option: define SEG_SCAN_LZS_EN to add leading-zero suppression on the
// active registers.
module seg_scan_driver #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250,
  parameter int PWM_BITS  = 4
) (
  input  logic                  CLK_50M,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic [PWM_BITS-1:0]   bright,
  input  logic                  load,
  output logic [7:0]            SEG_DATA,
  output logic [DIGITS-1:0]     SEG_EN,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // scan timing
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                frame_done_q;
  logic                tick, boundary;

  // blink timing
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  // shadow and active display registers
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0]   sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;

  // current-digit selection and outputs
  logic [DIGITS-1:0]   supp;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank, cur_blink, cur_supp;
  logic [DIGITS-1:0]   cur_en_n;
  logic                pwm_on, visible;
  logic [DIGITS-1:0]   seg_en_q, seg_en_d;
  logic [7:0]          seg_data_q, seg_data_d;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h58;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // Slot divider, digit index and free-running PWM counter next state
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    pwm_d = pwm_q + PWM_BITS'(1);
  end

  // Scan timing registers; frame_done is the boundary delayed by one clock
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      div_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      frame_done_q <= boundary;
    end
  end

  // Count completed frames and toggle the blink phase at each wrap
  always_comb begin
    blk_cnt_d     = blk_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  // Blink counter and phase registers (phase 0 = visible)
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Load writes the shadow set. The boundary copies the shadow set to the
  // active set. Because the active set copies the next shadow value, a load
  // that arrives on the boundary cycle goes straight through to the display.
  always_comb begin
    sh_data_d  = load ? digit_data : sh_data_q;
    sh_dp_d    = load ? dp_in      : sh_dp_q;
    sh_blank_d = load ? blank_in   : sh_blank_q;
    sh_blink_d = load ? blink_in   : sh_blink_q;
    act_data_d  = boundary ? sh_data_d  : act_data_q;
    act_dp_d    = boundary ? sh_dp_d    : act_dp_q;
    act_blank_d = boundary ? sh_blank_d : act_blank_q;
    act_blink_d = boundary ? sh_blink_d : act_blink_q;
  end

  // Shadow and active register banks
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_blink_q  <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_blink_q <= '0;
    end else begin
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_blink_q  <= sh_blink_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
    end
  end

`ifdef SEG_SCAN_LZS_EN
  // Leading zeros stay dark until the first nonzero nibble or the first lit
  // decimal point. The last digit is always shown.
  always_comb begin
    logic run;
    run  = 1'b1;
    supp = '0;
    for (int d = 0; d < DIGITS - 1; d++) begin
      run = run & (act_data_q[4*(DIGITS-1-d) +: 4] == 4'h0) & ~act_dp_q[d];
      supp[d] = run;
    end
  end
`else
  assign supp = '0;
`endif

  // Select the active controls for the digit in the current slot
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_supp  = 1'b0;
    cur_en_n  = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        cur_nib     = act_data_q[4*(DIGITS-1-d) +: 4];
        cur_dp      = act_dp_q[d];
        cur_blank   = act_blank_q[d];
        cur_blink   = act_blink_q[d];
        cur_supp    = supp[d];
        cur_en_n[d] = 1'b0;
      end
    end
  end

  // Output next state. The font is always presented and only the enable is
  // gated. The slot-end tick forces the next cycle dark, so adjacent digits
  // never overlap.
  always_comb begin
    pwm_on     = (pwm_q <= bright);
    visible    = pwm_on & ~cur_blank & ~cur_supp & ~(cur_blink & blink_phase_q);
    seg_data_d = {cur_dp, hex_font(cur_nib)};
    seg_en_d   = '1;
    if (!tick && visible) begin
      seg_en_d = cur_en_n;
    end
  end

  // Registered pin drivers; reset darkens the display immediately
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      seg_en_q   <= '1;
      seg_data_q <= 8'h00;
    end else begin
      seg_en_q   <= seg_en_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign SEG_EN     = seg_en_q;
  assign SEG_DATA   = seg_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
// Directed bench for seg_scan_driver with a short scan: 6 digits, 4 clocks per
// slot, blink every 2 frames and 2-bit brightness.
// After reset is released, k counts the rising edges. The outputs seen after
// edge k come from the state after k-1 edges. That state is:
//   frame = (k-1)/24, slot = ((k-1)/4)%6, div = pwm = (k-1)%4
module tb_seg_scan_driver;
  localparam int DIGITS = 6, SCAN_DIV = 4, BLINK_DIV = 2, PWM_BITS = 2;
`ifdef SEG_SCAN_LZS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic                CLK_50M = 1'b0;
  logic                RST_N   = 1'b1;
  logic [4*DIGITS-1:0] digit_data = '0;
  logic [DIGITS-1:0]   dp_in = '0, blank_in = '0, blink_in = '0;
  logic [PWM_BITS-1:0] bright = 2'd3;
  logic                load = 1'b0;
  logic [7:0]          SEG_DATA;
  logic [DIGITS-1:0]   SEG_EN;
  logic                frame_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .PWM_BITS(PWM_BITS)
  ) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .digit_data(digit_data), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .bright(bright), .load(load),
    .SEG_DATA(SEG_DATA), .SEG_EN(SEG_EN), .frame_done(frame_done)
  );

  always #5 CLK_50M = ~CLK_50M;

  always @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic at_k(input int k);
    if (cyc > k) begin
      n_err++;
      $display("FAIL sequencing: cycle %0d already past target %0d", cyc, k);
    end
    while (cyc < k) @(negedge CLK_50M);
  endtask

  task automatic slot(input string tag, input int k, input logic [5:0] en, input logic [7:0] data);
    at_k(k);
    chk({tag, "_en"}, 32'(SEG_EN), 32'(en));
    chk({tag, "_data"}, 32'(SEG_DATA), 32'(data));
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                         input logic [5:0] bk);
    digit_data = d;
    dp_in      = dp;
    blank_in   = bl;
    blink_in   = bk;
    load       = 1'b1;
    @(negedge CLK_50M);
    load       = 1'b0;
  endtask

  initial begin
    // reset state
    #1 RST_N = 1'b0;
    #2;
    chk("rst_en", 32'(SEG_EN), 32'h3F);
    chk("rst_data", 32'(SEG_DATA), 32'h00);
    chk("rst_fd", 32'(frame_done), 32'h0);
    repeat (3) @(negedge CLK_50M);
    RST_N = 1'b1;

    // frame 0 shows cleared active registers; a load affects only the shadow
    slot("f0_d0", 1, 6'b111110, 8'h3F);
    at_k(5);
    do_load(24'h123456, 6'h00, 6'h00, 6'h00);
    slot("f0_d1_shadow_only", 6, 6'b111101, 8'h3F);
    at_k(23); chk("fd_pre", 32'(frame_done), 32'h0);
    at_k(24); chk("fd_pulse", 32'(frame_done), 32'h1);
    chk("post_tick_dark", 32'(SEG_EN), 32'h3F);
    at_k(25); chk("fd_one_cycle", 32'(frame_done), 32'h0);
    slot("f1_d0", 26, 6'b111110, 8'h06);
    slot("f1_d5", 46, 6'b011111, 8'h7D);
    at_k(48); chk("fd_period", 32'(frame_done), 32'h1);

    // load in the middle of a frame (slot 2) takes effect at the next frame
    at_k(56);
    do_load(24'hABCDEF, 6'h00, 6'h00, 6'h00);
    slot("f2_d3_old", 62, 6'b110111, 8'h66);
    slot("f2_d5_old", 70, 6'b011111, 8'h7D);
    slot("f3_d0_new", 74, 6'b111110, 8'h77);
    slot("f3_d2_new", 82, 6'b111011, 8'h58);

    // load on the boundary cycle bypasses the shadow into the next frame
    at_k(95);
    do_load(24'h987654, 6'h00, 6'h00, 6'h00);
    slot("f4_d0_bypass", 98, 6'b111110, 8'h6F);
    slot("f4_d1_bypass", 102, 6'b111101, 8'h7F);
    slot("f5_d0_shadow", 122, 6'b111110, 8'h6F);

    // bright=0: lit only on the pwm==0 clock of the slot
    at_k(124);
    bright = 2'd0;
    slot("pwm0_on", 125, 6'b111101, 8'h7F);
    slot("pwm0_off1", 126, 6'b111111, 8'h7F);
    slot("pwm0_off2", 127, 6'b111111, 8'h7F);
    at_k(128); chk("pwm0_tick", 32'(SEG_EN), 32'h3F);
    bright = 2'd3;

    // blink digit 0, blank digit 5 (active from frame 6; blink phase 1 in frames 6,7)
    at_k(130);
    do_load(24'h987654, 6'h00, 6'b100000, 6'b000001);
    slot("f6_d0_blinkoff", 146, 6'b111111, 8'h6F);
    slot("f6_d1", 150, 6'b111101, 8'h7F);
    slot("f6_d5_blank", 166, 6'b111111, 8'h66);
    slot("f7_d0_blinkoff", 170, 6'b111111, 8'h6F);
    slot("f8_d0_blinkon", 194, 6'b111110, 8'h6F);
    slot("f8_d5_blank", 214, 6'b111111, 8'h66);

    // leading zeros: 000120, active in frame 10
    at_k(216);
    do_load(24'h000120, 6'h00, 6'h00, 6'h00);
    slot("lz_d0", 242, LZS ? 6'b111111 : 6'b111110, 8'h3F);
    slot("lz_d2", 250, LZS ? 6'b111111 : 6'b111011, 8'h3F);
    slot("lz_d3", 254, 6'b110111, 8'h06);
    slot("lz_d4", 258, 6'b101111, 8'h5B);
    slot("lz_d5", 262, 6'b011111, 8'h3F);

    // all zeros: only digit 5 remains when suppression is on (frame 12)
    at_k(264);
    do_load(24'h000000, 6'h00, 6'h00, 6'h00);
    slot("z_d0", 290, LZS ? 6'b111111 : 6'b111110, 8'h3F);
    slot("z_d4", 306, LZS ? 6'b111111 : 6'b101111, 8'h3F);
    slot("z_d5", 310, 6'b011111, 8'h3F);

    // a lit dp on digit 1 ends suppression there (frame 14)
    at_k(312);
    do_load(24'h000000, 6'b000010, 6'h00, 6'h00);
    slot("dp_d0", 338, LZS ? 6'b111111 : 6'b111110, 8'h3F);
    slot("dp_d1", 342, 6'b111101, 8'hBF);
    slot("dp_d2", 346, 6'b111011, 8'h3F);
    slot("dp_d3_prerst", 350, 6'b110111, 8'h3F);

    // asynchronous reset in the middle of a slot
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_en", 32'(SEG_EN), 32'h3F);
    chk("mid_rst_data", 32'(SEG_DATA), 32'h00);
    chk("mid_rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge CLK_50M);
    RST_N = 1'b1;
    slot("rr_d0", 2, 6'b111110, 8'h3F);
    slot("rr_d1", 6, 6'b111101, 8'h3F);
    at_k(24); chk("rr_fd", 32'(frame_done), 32'h1);
    slot("rr_f1_d1_shadow_clr", 30, 6'b111101, 8'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
